// File: rtl/coin_collector.sv
// coin_collector: vending coin/credit FSM with vault balance, change return and owner withdrawal.
// Optional macro COIN_COUNT_EN adds a saturating 16-bit count of accepted coins.
module coin_collector (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        coin_valid,
    input  logic [1:0]  coin_type,
    input  logic        buy,
    input  logic [7:0]  item_price,
    input  logic        cancel,
    input  logic        change_ack,
    input  logic        mode,
    input  logic [10:0] new_machine_money,
`ifdef COIN_COUNT_EN
    output logic [15:0] coin_count,
`endif
    output logic [10:0] machine_money,
    output logic [10:0] credit,
    output logic        dispense,
    output logic        vend_fail,
    output logic        coin_reject,
    output logic        change_valid,
    output logic [10:0] change,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, OWNER} state_t;
    state_t state;
    logic [7:0] price;
    logic [10:0] coin_val, sum, rem;
    logic [11:0] vault_sum;
    logic coin_fits, buy_ok;

    always_comb begin
        coin_val = coin_type == 2'd0 ? 11'd1 : coin_type == 2'd1 ? 11'd5 : coin_type == 2'd2 ? 11'd10 : 11'd25;
        sum = credit + coin_val;
        rem = credit - {3'd0, price};
        vault_sum = {1'b0, machine_money} + {4'd0, item_price};
        coin_fits = sum <= 11'd255;
        buy_ok = item_price != 8'd0 && credit >= {3'd0, item_price} && vault_sum <= 12'd2047;
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            price <= '0;
            machine_money <= '0;
            credit <= '0;
            change <= '0;
            change_valid <= 1'b0;
            dispense <= 1'b0;
            vend_fail <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            dispense <= 1'b0;
            vend_fail <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    vend_fail <= buy;
                    if (mode) begin
                        coin_reject <= coin_valid;
                        state <= OWNER;
                    end else if (coin_valid) begin
                        credit <= coin_val;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        coin_reject <= coin_valid;
                        change_valid <= 1'b1;
                        change <= credit;
                        state <= CHANGE;
                    end else if (buy) begin
                        coin_reject <= coin_valid;
                        if (buy_ok) begin
                            price <= item_price;
                            dispense <= 1'b1;
                            state <= VEND;
                        end else
                            vend_fail <= 1'b1;
                    end else if (coin_valid) begin
                        if (coin_fits)
                            credit <= sum;
                        else
                            coin_reject <= 1'b1;
                    end
                end
                VEND: begin
                    coin_reject <= coin_valid;
                    credit <= rem;
                    machine_money <= machine_money + {3'd0, price};
                    if (rem != 11'd0) begin
                        change_valid <= 1'b1;
                        change <= rem;
                        state <= CHANGE;
                    end else
                        state <= IDLE;
                end
                CHANGE: begin
                    coin_reject <= coin_valid;
                    if (change_ack) begin
                        credit <= '0;
                        change <= '0;
                        change_valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                OWNER: begin
                    coin_reject <= coin_valid;
                    vend_fail <= buy;
                    if (!mode) begin
                        machine_money <= new_machine_money;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COIN_COUNT_EN
    logic coin_ok;
    assign coin_ok = coin_valid && ((state == IDLE && !mode) || (state == COLLECT && !cancel && !buy && coin_fits));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coin_count <= '0;
        else if (coin_ok && coin_count != 16'hFFFF)
            coin_count <= coin_count + 16'd1;
    end
`endif
endmodule

// File: doc/coin_collector.md
COIN_COLLECTOR -- requirements
Module: coin_collector

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 coin_valid  in  1  one-cycle pulse: coin inserted.
REQ-004 coin_type  in  2  coin value when coin_valid=1: 00=1, 01=5, 10=10, 11=25 units.
REQ-005 buy  in  1  one-cycle pulse: purchase request.
REQ-006 item_price  in  8  price in units, sampled when buy=1.
REQ-007 cancel  in  1  one-cycle pulse: customer aborts, requests refund.
REQ-008 change_ack  in  1  customer took returned change.
REQ-009 mode  in  1  1 = owner withdrawal mode (same signal driven to owner_money stage).
REQ-010 new_machine_money  in  11  post-withdrawal balance returned by owner_money stage.
REQ-011 machine_money  out  11  registered vault balance, feeds owner_money stage.
REQ-012 credit  out  11  registered customer credit, range 0..255.
REQ-013 dispense  out  1  registered one-cycle pulse: item released.
REQ-014 vend_fail  out  1  registered one-cycle pulse: buy refused.
REQ-015 coin_reject  out  1  registered one-cycle pulse: coin returned, not credited.
REQ-016 change_valid  out  1  change on change output is valid.
REQ-017 change  out  11  refund amount, valid while change_valid=1.
REQ-018 busy  out  1  1 whenever state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, COLLECT, VEND, CHANGE, OWNER, all transitions on rising clk.
REQ-020 IDLE: mode=1 -> OWNER (coins rejected); else coin_valid -> credit=value, -> COLLECT; buy -> vend_fail pulse; cancel ignored.
REQ-021 COLLECT coin: credit += value if result <= 255, else coin_reject pulse and credit unchanged.
REQ-022 COLLECT priority per cycle: cancel > buy > coin; a coin coinciding with cancel or buy SHALL produce coin_reject.
REQ-023 COLLECT buy: if item_price != 0, credit >= item_price and machine_money + item_price <= 2047 -> latch price, -> VEND; else vend_fail pulse, stay COLLECT.
REQ-024 COLLECT cancel -> CHANGE.
REQ-025 VEND (exactly one cycle): dispense pulse, credit -= price, machine_money += price; -> CHANGE if new credit > 0, else IDLE.
REQ-026 CHANGE: change_valid=1, change=credit; coins rejected, buy/cancel ignored; on change_ack: credit=0, change_valid=0, -> IDLE next cycle.
REQ-027 OWNER: machine_money held constant while mode=1; coins rejected; buy -> vend_fail; on first cycle with mode=0, machine_money <= new_machine_money, -> IDLE.
REQ-028 mode=1 outside IDLE SHALL be ignored until the FSM returns to IDLE.
REQ-029 All arithmetic 11-bit unsigned; no wrap-around permitted by REQ-021/023 guards.
REQ-030 Pulse outputs SHALL assert exactly one cycle after the triggering input edge.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, machine_money=0, credit=0, change=0 and all pulse/flag outputs 0, including mid-VEND or mid-CHANGE; pending credit is discarded.
REQ-032 First state update SHALL occur on the first rising clk after rst_n deasserts.

Configuration
REQ-033 Macro COIN_COUNT_EN: when defined, add output coin_count (16 bits), incremented per accepted coin, saturating at 65535, cleared by reset only; when undefined, the port and counter SHALL not exist and all other behaviour is identical.

Verification
REQ-034 Reset; coins 25,25,10; buy price 50 -> dispense pulse, machine_money=50, change_valid=1 with change=10; change_ack -> credit=0, IDLE.
REQ-035 Credit 250; coin 10 -> coin_reject, credit stays 250; coin 5 -> credit 255.
REQ-036 Credit 30; buy price 40 -> vend_fail, credit 30; cancel -> change=30; change_ack -> IDLE.
REQ-037 machine_money 2040, credit 10; buy price 10 -> vend_fail (vault full); machine_money unchanged.
REQ-038 IDLE, machine_money 1024, mode=1, coin offered -> coin_reject; new_machine_money=0, mode=0 -> machine_money=0, IDLE.
REQ-039 rst_n low during CHANGE with change=15 -> all outputs 0 at once, state IDLE; with COIN_COUNT_EN, coin_count=0.
